// File: rtl/key_disp_pkg.sv
// Shared types and defaults for the key-code display feeder: FSM states,
// display geometry and the key-byte framing check.
package key_disp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    CAP  = 2'd2
  } state_t;

  localparam int         DIGITS_DEF     = 6;
  localparam logic [3:0] BLANK_CODE_DEF = 4'hF;

  // A key byte is framed as the same nibble sent twice.
  function automatic logic is_valid_key_byte(input logic [7:0] key_byte);
    return key_byte[7:4] == key_byte[3:0];
  endfunction

endpackage

// File: rtl/pop_pacer.sv
// Saturating interval counter: ready goes high POP_INTERVAL-1 cycles after
// restart (or reset) drops and stays high until the next restart.
module pop_pacer #(
  parameter int POP_INTERVAL = 25_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic restart,
  output logic ready
);

  localparam int            CW   = (POP_INTERVAL > 2) ? $clog2(POP_INTERVAL) : 2;
  localparam logic [CW-1:0] LAST = CW'(POP_INTERVAL - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge sys_clk) begin
    if (sys_rst || restart) begin
      r_cnt <= '0;
    end else if (r_cnt != LAST) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign ready = (r_cnt == LAST);

endmodule

// File: rtl/key_disp_feeder.sv
// Paced reader for the key-code FIFO: pops one byte per interval, validates
// it and shifts its key nibble into a blank-filled digit history.
module key_disp_feeder
  import key_disp_pkg::*;
#(
  parameter int         POP_INTERVAL = 25_000_000,
  parameter int         DIGITS       = DIGITS_DEF,
  parameter logic [3:0] BLANK_CODE   = BLANK_CODE_DEF,
  localparam int        CNT_W        = $clog2(DIGITS + 1)
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                fifo_empty,
  input  logic [7:0]          fifo_q,
  output logic                fifo_rdreq,
  input  logic                clear,
  input  logic                hold,
  output logic [4*DIGITS-1:0] disp_data,
  output logic [CNT_W-1:0]    digit_cnt,
  output logic                new_flag,
  output logic                frame_err
);

  state_t              r_state;
  state_t              w_state_next;
  logic                w_pop;
  logic                w_ready;
  logic                w_restart;
  logic                w_in_cap;
  logic                w_byte_ok;
  logic                w_shift;
  logic                w_bad;
  logic                r_rdreq;
  logic                r_new;
  logic                r_err;
  logic [CNT_W-1:0]    r_cnt;
  logic [4*DIGITS-1:0] w_hist;

  pop_pacer #(
    .POP_INTERVAL(POP_INTERVAL)
  ) u_pacer (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .restart (w_restart),
    .ready   (w_ready)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Once REQ is entered the read always completes, keeping the FIFO pointer honest.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_ready && !fifo_empty && !hold) begin
          w_state_next = REQ;
          w_pop        = 1'b1;
        end
      end
      REQ:     w_state_next = CAP;
      CAP:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign w_restart = (r_state == REQ);
  assign w_in_cap  = (r_state == CAP);
  assign w_byte_ok = is_valid_key_byte(fifo_q);
  assign w_shift   = w_in_cap && w_byte_ok && !clear;
  assign w_bad     = w_in_cap && !w_byte_ok && !clear;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_rdreq <= 1'b0;
      r_new   <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_rdreq <= w_pop;
      r_new   <= w_shift;
      if (clear) begin
        r_cnt <= '0;
        r_err <= 1'b0;
      end else begin
        if (w_shift && (r_cnt != CNT_W'(DIGITS))) begin
          r_cnt <= r_cnt + 1'b1;
        end
        if (w_bad) begin
          r_err <= 1'b1;
        end
      end
    end
  end

  // Digit 0 is the newest; each slot takes its younger neighbour on a shift.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic [3:0] r_digit;
    logic [3:0] w_src;

    if (gi == 0) begin : g_head
      assign w_src = fifo_q[3:0];
    end else begin : g_tail
      assign w_src = w_hist[4*(gi-1) +: 4];
    end

    always_ff @(posedge sys_clk) begin
      if (sys_rst || clear) begin
        r_digit <= BLANK_CODE;
      end else if (w_shift) begin
        r_digit <= w_src;
      end
    end

    assign w_hist[4*gi +: 4] = r_digit;
  end

  assign fifo_rdreq = r_rdreq;
  assign disp_data  = w_hist;
  assign digit_cnt  = r_cnt;
  assign new_flag   = r_new;
  assign frame_err  = r_err;

endmodule

// File: tb/tb_key_disp_feeder.sv
// Bench for key_disp_feeder: behavioural FIFO, timeline reference model and
// directed plus randomized scenarios with POP_INTERVAL=4.
module tb_key_disp_feeder;

  localparam int P = 4;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        fifo_empty;
  logic [7:0]  fifo_q = 8'h00;
  logic        fifo_rdreq;
  logic        clear;
  logic        hold;
  logic [23:0] disp_data;
  logic [2:0]  digit_cnt;
  logic        new_flag;
  logic        frame_err;

  int checks = 0;
  int errors = 0;

  key_disp_feeder #(
    .POP_INTERVAL(P),
    .DIGITS      (6),
    .BLANK_CODE  (4'hF)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .fifo_empty (fifo_empty),
    .fifo_q     (fifo_q),
    .fifo_rdreq (fifo_rdreq),
    .clear      (clear),
    .hold       (hold),
    .disp_data  (disp_data),
    .digit_cnt  (digit_cnt),
    .new_flag   (new_flag),
    .frame_err  (frame_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Behavioural non-showahead FIFO
  logic [7:0] fmem [256];
  int wp = 0;
  int rp = 0;
  assign fifo_empty = (wp == rp);

  always @(posedge sys_clk) begin
    if (fifo_rdreq && (wp != rp)) begin
      fifo_q <= fmem[rp[7:0]];
      rp     <= rp + 1;
    end
  end

  // Reference model: timeline rules of the pop schedule plus a digit history
  logic [7:0]  mq[$];
  logic [7:0]  cap_byte = 8'h00;
  logic [23:0] m_disp = 24'hFFFFFF;
  int          m_cnt = 0;
  bit          m_err = 1'b0;
  bit          exp_rdreq = 1'b0;
  bit          exp_new = 1'b0;
  int          cyc = 0;
  int          last_req = -100;
  int          pace_base = 0;
  int          last_seen = -1;
  int          pops = 0;
  int          news = 0;

  always @(negedge sys_clk) begin
    bit nxt_rdreq;
    bit nxt_new;
    cyc++;
    chk("rdreq", fifo_rdreq, exp_rdreq);
    chk("new_flag", new_flag, exp_new);
    chk("disp_data", disp_data, m_disp);
    chk("digit_cnt", digit_cnt, m_cnt);
    chk("frame_err", frame_err, m_err);
    if (fifo_rdreq) begin
      pops++;
      if (last_seen >= 0) chk("pop_spacing", (cyc - last_seen) >= (P + 1), 1'b1);
      last_seen = cyc;
    end
    if (new_flag) news++;

    nxt_rdreq = 1'b0;
    nxt_new   = 1'b0;
    if (exp_rdreq && mq.size() > 0) cap_byte = mq.pop_front();
    if (sys_rst) begin
      m_disp    = 24'hFFFFFF;
      m_cnt     = 0;
      m_err     = 1'b0;
      last_req  = -100;
      pace_base = cyc;
    end else begin
      if (clear) begin
        m_disp = 24'hFFFFFF;
        m_cnt  = 0;
        m_err  = 1'b0;
      end else if (cyc == last_req + 1) begin
        if (cap_byte[7:4] == cap_byte[3:0]) begin
          m_disp  = {m_disp[19:0], cap_byte[3:0]};
          m_cnt   = (m_cnt < 6) ? m_cnt + 1 : 6;
          nxt_new = 1'b1;
        end else begin
          m_err = 1'b1;
        end
      end
      if (exp_rdreq) begin
        last_req  = cyc;
        pace_base = cyc;
      end else if ((cyc != last_req + 1) && (cyc >= pace_base + P) &&
                   (mq.size() > 0) && !hold) begin
        nxt_rdreq = 1'b1;
      end
    end
    exp_rdreq = nxt_rdreq;
    exp_new   = nxt_new;
  end

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    fmem[wp[7:0]] = b;
    mq.push_back(b);
    wp++;
  endtask

  initial begin
    int  p0;
    int  n0;
    bit  seen;
    logic [3:0] nib;

    sys_rst = 1'b1;
    clear   = 1'b0;
    hold    = 1'b0;
    step(3);
    sys_rst = 1'b0;

    // Idle with an empty FIFO
    step(50);
    chk("s1_disp", disp_data, 24'hFFFFFF);
    chk("s1_cnt", digit_cnt, 3'd0);
    chk("s1_pops", pops, 0);
    chk("s1_news", news, 0);

    // Three valid keys
    p0 = pops; n0 = news;
    push(8'h33); push(8'h77); push(8'hAA);
    step(40);
    chk("s2_disp", disp_data, 24'hFFF37A);
    chk("s2_cnt", digit_cnt, 3'd3);
    chk("s2_pops", pops - p0, 3);
    chk("s2_news", news - n0, 3);

    // History overflow
    for (int i = 1; i <= 8; i++) push({i[3:0], i[3:0]});
    step(60);
    chk("s3_disp", disp_data, 24'h345678);
    chk("s3_cnt", digit_cnt, 3'd6);

    // Malformed byte in the middle
    clear = 1'b1; step(1); clear = 1'b0;
    n0 = news;
    push(8'h22); push(8'h3C); push(8'h55);
    step(40);
    chk("s4_ferr", frame_err, 1'b1);
    chk("s4_disp", disp_data, 24'hFFFF25);
    chk("s4_news", news - n0, 2);

    // Hold blocks pops; release gives a pop one cycle later
    clear = 1'b1; step(1); clear = 1'b0;
    hold = 1'b1;
    p0 = pops;
    push(8'h44);
    step(20);
    chk("s5_held_pops", pops - p0, 0);
    hold = 1'b0;
    chk("s5_rdreq_low", fifo_rdreq, 1'b0);
    step(1);
    chk("s5_rdreq_latency", fifo_rdreq, 1'b1);
    step(10);
    chk("s5_disp", disp_data, 24'hFFFFF4);
    chk("s5_ferr", frame_err, 1'b0);

    // Clear landing on the capture cycle
    n0 = news;
    push(8'h99);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1);
      if (fifo_rdreq) seen = 1'b1;
    end
    chk("s6_pop_seen", seen, 1'b1);
    step(1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    step(5);
    chk("s6_disp", disp_data, 24'hFFFFFF);
    chk("s6_cnt", digit_cnt, 3'd0);
    chk("s6_news", news - n0, 0);
    chk("s6_fifo_drained", rp, wp);

    // Randomized traffic, control pulses and occasional mid-flight reset
    for (int i = 0; i < 600; i++) begin
      if (mq.size() < 8 && $urandom_range(0, 3) == 0) begin
        nib = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 3) != 0) push({nib, nib});
        else push(8'($urandom_range(0, 255)));
      end
      hold    = ($urandom_range(0, 7) == 0);
      clear   = ($urandom_range(0, 31) == 0);
      sys_rst = ($urandom_range(0, 149) == 0);
      step(1);
    end
    hold = 1'b0; clear = 1'b0; sys_rst = 1'b0;
    step(80);
    chk("s7_fifo_drained", rp, wp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
